// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared types and constants for the fetch front end.
//   INST_FETCH_NUM : instructions per fetch bundle (global macro, power of two, >= 2).
//   ib_entry_t     : one fetch-buffer slot {valid, pc, inst}.
//   fetch_state_t  : fetch FSM states.
//   bundle_base()  : clears the in-bundle offset bits of a PC.
`ifndef INST_FETCH_NUM
`define INST_FETCH_NUM 4
`endif

package inst_fetch_pkg;

    localparam int unsigned FETCH_NUM    = `INST_FETCH_NUM;
    localparam int unsigned BUNDLE_BYTES = 4 * FETCH_NUM;
    localparam int unsigned OFS          = $clog2(BUNDLE_BYTES);
    localparam logic [31:0] RESET_PC     = 32'h8000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } ib_entry_t;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_HOLD
    } fetch_state_t;

    function automatic logic [31:0] bundle_base(input logic [31:0] pc);
        return pc & ~32'(BUNDLE_BYTES - 1);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: I-cache request/response, backend redirect and fetch-buffer
// write-side signals of the fetch unit.
//   master : the fetch unit (drives request and push side).
//   slave  : the environment (I-cache, backend, fetch buffer).
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic                          icache_req_valid;
    logic [31:0]                   icache_req_addr;
    logic                          icache_req_ready;
    logic                          icache_resp_valid;
    logic [32*FETCH_NUM-1:0]       icache_resp_data;
    logic                          redirect_valid;
    logic [31:0]                   redirect_pc;
    logic                          fb_full;
    ib_entry_t [FETCH_NUM-1:0]     insts_out;
    logic                          insts_out_valid;

    modport master (
        output icache_req_valid, icache_req_addr, insts_out, insts_out_valid,
        input  icache_req_ready, icache_resp_valid, icache_resp_data,
               redirect_valid, redirect_pc, fb_full
    );

    modport slave (
        input  icache_req_valid, icache_req_addr, insts_out, insts_out_valid,
        output icache_req_ready, icache_resp_valid, icache_resp_data,
               redirect_valid, redirect_pc, fb_full
    );

endinterface

// File: rtl/inst_fetch_bundle_align.sv
// inst_fetch_bundle_align: combinational slot builder.
//   data  : raw I-cache bundle, slot i at bits [32i+31:32i].
//   pc    : fetch PC (may point into the middle of the bundle).
//   slots : one ib_entry_t per instruction; slots before the start PC are invalid.
module inst_fetch_bundle_align
    import inst_fetch_pkg::*;
(
    input  logic [32*FETCH_NUM-1:0]   data,
    input  logic [31:0]               pc,
    output ib_entry_t [FETCH_NUM-1:0] slots
);

    logic [31:0] base;
    assign base = bundle_base(pc);

    for (genvar i = 0; i < FETCH_NUM; i++) begin : g_slot
        assign slots[i].inst  = data[32*i +: 32];
        assign slots[i].pc    = base + 32'(4 * i);
        // Word index of the start PC inside the bundle gates earlier slots.
        assign slots[i].valid = 32'(i) >= 32'(pc[OFS-1:2]);
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetch unit driving the write side of the fetch buffer.
// One I-cache request in flight; the returned bundle is held until the fetch
// buffer accepts it, then the next sequential bundle is requested. A backend
// redirect overrides every same-cycle event and restarts fetch at its PC.
//   clk   : clock, rising edge.
//   reset : asynchronous, active-low.
//   fif   : inst_fetch_if.master (I-cache, redirect, fetch-buffer signals).
// Optional (FETCH_PERF_EN): perf_bundle_cnt, perf_stall_cnt, perf_redirect_cnt.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    inst_fetch_if.master fif
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_bundle_cnt,
    output logic [31:0]  perf_stall_cnt,
    output logic [31:0]  perf_redirect_cnt
`endif
);

    fetch_state_t              state, state_nxt;
    logic [31:0]               pc, pc_nxt;
    logic                      drop, drop_nxt;
    logic [32*FETCH_NUM-1:0]   bundle;
    logic                      bundle_ld;
    logic                      req, push, redir;
    ib_entry_t [FETCH_NUM-1:0] slots;

    // Redirects are ignored only in the single post-reset IDLE cycle.
    assign redir = fif.redirect_valid && (state != FS_IDLE);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        bundle_ld = 1'b0;
        req       = 1'b0;
        push      = 1'b0;
        case (state)
            FS_IDLE: state_nxt = FS_REQ;
            FS_REQ: begin
                req = !fif.redirect_valid;
                if (req && fif.icache_req_ready) state_nxt = FS_WAIT;
            end
            FS_WAIT: begin
                if (fif.icache_resp_valid) begin
                    // A response arriving with (or after) a redirect is stale.
                    if (drop || redir) begin
                        drop_nxt  = 1'b0;
                        state_nxt = FS_REQ;
                    end else begin
                        bundle_ld = 1'b1;
                        state_nxt = FS_HOLD;
                    end
                end else if (redir) begin
                    drop_nxt = 1'b1;
                end
            end
            FS_HOLD: begin
                push = !fif.fb_full && !fif.redirect_valid;
                if (push) begin
                    pc_nxt    = bundle_base(pc) + 32'(BUNDLE_BYTES);
                    state_nxt = FS_REQ;
                end else if (redir) begin
                    state_nxt = FS_REQ;
                end
            end
            default: state_nxt = FS_IDLE;
        endcase
        if (redir) pc_nxt = fif.redirect_pc & ~32'h3;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FS_IDLE;
            pc     <= RESET_PC;
            drop   <= 1'b0;
            bundle <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            drop  <= drop_nxt;
            if (bundle_ld) bundle <= fif.icache_resp_data;
        end
    end

    inst_fetch_bundle_align u_align (
        .data  (bundle),
        .pc    (pc),
        .slots (slots)
    );

    assign fif.icache_req_valid = req;
    assign fif.icache_req_addr  = (state == FS_REQ) ? bundle_base(pc) : '0;
    assign fif.insts_out_valid  = push;
    assign fif.insts_out        = (state == FS_HOLD) ? slots : '0;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_bundle_cnt   <= '0;
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (push) perf_bundle_cnt <= perf_bundle_cnt + 32'd1;
            if (state == FS_HOLD && fif.fb_full) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redir) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with a transaction-level
// reference model (expected next fetch PC, outstanding request, held bundle)
// checked every cycle at the falling edge, plus literal expectations per phase.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    typedef ib_entry_t [FETCH_NUM-1:0] bund_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_fetch_if dif ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_bundle_cnt, perf_stall_cnt, perf_redirect_cnt;
`endif

    inst_fetch dut (
        .clk   (clk),
        .reset (reset),
        .fif   (dif)
`ifdef FETCH_PERF_EN
        ,
        .perf_bundle_cnt   (perf_bundle_cnt),
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    bit          m_pend, m_drop, m_held, m_idle;
    bund_t       m_bund;
    int          cyc;
    int          p_bund, p_stall, p_redir;
    logic [31:0] req_log[$];
    bund_t       push_log[$];
    int          push_cyc[$];

    function automatic bund_t model_bundle(input logic [32*FETCH_NUM-1:0] d, input logic [31:0] pc);
        bund_t       b;
        logic [31:0] ofs  = pc % 32'(BUNDLE_BYTES);
        logic [31:0] base = pc - ofs;
        for (int i = 0; i < FETCH_NUM; i++) begin
            b[i].inst  = d[32*i +: 32];
            b[i].pc    = base + 32'(4 * i);
            b[i].valid = 32'(4 * i) >= ofs;
        end
        return b;
    endfunction

    initial begin
        bit exp_req, exp_push;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                chk("rst_req_valid", 320'(dif.icache_req_valid), 320'(0));
                chk("rst_req_addr", 320'(dif.icache_req_addr), 320'(0));
                chk("rst_push", 320'(dif.insts_out_valid), 320'(0));
                chk("rst_insts_out", 320'(dif.insts_out), 320'(0));
`ifdef FETCH_PERF_EN
                chk("rst_perf", 320'({perf_bundle_cnt, perf_stall_cnt, perf_redirect_cnt}), 320'(0));
`endif
                m_pc = RESET_PC; m_pend = 0; m_drop = 0; m_held = 0; m_idle = 1;
                m_bund = '0; p_bund = 0; p_stall = 0; p_redir = 0;
            end else begin
`ifdef FETCH_PERF_EN
                chk("perf_bundle", 320'(perf_bundle_cnt), 320'(p_bund));
                chk("perf_stall", 320'(perf_stall_cnt), 320'(p_stall));
                chk("perf_redirect", 320'(perf_redirect_cnt), 320'(p_redir));
`endif
                if (m_idle) begin
                    chk("idle_req_valid", 320'(dif.icache_req_valid), 320'(0));
                    chk("idle_push", 320'(dif.insts_out_valid), 320'(0));
                    m_idle = 0;
                end else begin
                    exp_req  = !m_pend && !m_held && !dif.redirect_valid;
                    exp_push = m_held && !dif.fb_full && !dif.redirect_valid;
                    chk("req_valid", 320'(dif.icache_req_valid), 320'(exp_req));
                    if (exp_req) chk("req_addr", 320'(dif.icache_req_addr), 320'(m_pc - m_pc % 32'(BUNDLE_BYTES)));
                    chk("push", 320'(dif.insts_out_valid), 320'(exp_push));
                    if (m_held) chk("bundle", 320'(dif.insts_out), 320'(m_bund));
                    if (dif.icache_req_valid && dif.icache_req_ready) req_log.push_back(dif.icache_req_addr);
                    if (dif.insts_out_valid) begin
                        push_log.push_back(dif.insts_out);
                        push_cyc.push_back(cyc);
                    end
                    if (exp_push) p_bund++;
                    if (m_held && dif.fb_full) p_stall++;
                    if (dif.redirect_valid) p_redir++;
                    // Events taking effect at the coming rising edge.
                    if (dif.icache_resp_valid && m_pend) begin
                        m_pend = 0;
                        if (!m_drop && !dif.redirect_valid) begin
                            m_held = 1;
                            m_bund = model_bundle(dif.icache_resp_data, m_pc);
                        end
                        m_drop = 0;
                    end
                    if (dif.redirect_valid) begin
                        m_pc   = dif.redirect_pc - dif.redirect_pc % 32'd4;
                        m_held = 0;
                        if (m_pend) m_drop = 1;
                    end else begin
                        if (exp_req && dif.icache_req_ready) m_pend = 1;
                        if (exp_push) begin
                            m_held = 0;
                            m_pc   = m_pc - m_pc % 32'(BUNDLE_BYTES) + 32'(BUNDLE_BYTES);
                        end
                    end
                end
            end
        end
    end

    // ---------------- I-cache responder and stimulus ----------------
    bit          acc;
    logic [31:0] acc_addr, resp_addr;
    int          lat = 1;
    int          resp_cnt = 0;
    int          seq = 1;

    function automatic logic [32*FETCH_NUM-1:0] mk_data(input logic [31:0] a, input int s);
        logic [32*FETCH_NUM-1:0] d;
        for (int i = 0; i < FETCH_NUM; i++) d[32*i +: 32] = {8'(s), 4'(i), a[19:0]};
        return d;
    endfunction

    task automatic tick();
        @(negedge clk);
        acc      = dif.icache_req_valid && dif.icache_req_ready && reset;
        acc_addr = dif.icache_req_addr;
        @(posedge clk);
        #1;
        dif.redirect_valid    = 1'b0;
        dif.icache_resp_valid = 1'b0;
        if (acc) begin
            resp_cnt  = lat;
            resp_addr = acc_addr;
        end
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                dif.icache_resp_valid = 1'b1;
                dif.icache_resp_data  = mk_data(resp_addr, seq);
                seq++;
            end
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        dif.redirect_valid = 1'b1;
        dif.redirect_pc    = pc;
    endtask

    task automatic clear_logs();
        req_log.delete(); push_log.delete(); push_cyc.delete();
    endtask

    task automatic wait_push(input int n);
        for (int k = 0; k < 80 && push_log.size() < n; k++) tick();
        chk("wait_push", 320'(push_log.size() >= n), 320'(1));
    endtask

    task automatic wait_acc();
        for (int k = 0; k < 80; k++) begin
            tick();
            if (acc) break;
        end
        chk("wait_acc", 320'(acc), 320'(1));
    endtask

    task automatic wait_held();
        for (int k = 0; k < 80 && !m_held; k++) tick();
        chk("wait_held", 320'(m_held), 320'(1));
    endtask

    function automatic logic [31:0] rq(input int i);
        return (req_log.size() > i) ? req_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic bund_t pb(input int i);
        return (push_log.size() > i) ? push_log[i] : bund_t'(0);
    endfunction

    function automatic logic [FETCH_NUM-1:0] vmask(input bund_t b);
        logic [FETCH_NUM-1:0] m;
        for (int i = 0; i < FETCH_NUM; i++) m[i] = b[i].valid;
        return m;
    endfunction

    initial begin
        bund_t b;
        reset = 1'b0;
        dif.icache_req_ready  = 1'b1;
        dif.icache_resp_valid = 1'b0;
        dif.icache_resp_data  = '0;
        dif.redirect_valid    = 1'b0;
        dif.redirect_pc       = '0;
        dif.fb_full           = 1'b0;
        repeat (3) tick();
        reset = 1'b1;

        // Sequential fetch, L=1: one bundle every 3 cycles.
        for (int k = 0; k < 60 && req_log.size() < 4; k++) tick();
        chk("p1_req0", 320'(rq(0)), 320'(32'h8000_0000));
        chk("p1_req1", 320'(rq(1)), 320'(32'h8000_0010));
        chk("p1_req2", 320'(rq(2)), 320'(32'h8000_0020));
        chk("p1_period", 320'(push_cyc.size() > 1 ? push_cyc[1] - push_cyc[0] : 0), 320'(3));
        b = pb(0);
        chk("p1_mask", 320'(vmask(b)), 320'(4'hF));
        chk("p1_slot3_pc", 320'(b[3].pc), 320'(32'h8000_000C));

        // Unaligned redirect.
        tick();
        redirect(32'h8000_0108);
        clear_logs();
        wait_push(1);
        b = pb(0);
        chk("p2_req", 320'(rq(0)), 320'(32'h8000_0100));
        chk("p2_mask", 320'(vmask(b)), 320'(4'b1100));
        chk("p2_slot2_pc", 320'(b[2].pc), 320'(32'h8000_0108));
        chk("p2_slot3_pc", 320'(b[3].pc), 320'(32'h8000_010C));

        // Fetch buffer full while holding.
        dif.fb_full = 1'b1;
        wait_held();
        clear_logs();
        repeat (10) tick();
        chk("p3_no_push", 320'(push_log.size()), 320'(0));
        chk("p3_no_req", 320'(req_log.size()), 320'(0));
        dif.fb_full = 1'b0;
        tick();
        chk("p3_push_on_release", 320'(push_log.size()), 320'(1));

        // Redirect in WAIT with the response in the same cycle.
        lat = 1;
        wait_acc();
        redirect(32'h8000_0200);
        clear_logs();
        wait_push(1);
        b = pb(0);
        chk("p4a_req", 320'(rq(0)), 320'(32'h8000_0200));
        chk("p4a_pc", 320'(b[0].pc), 320'(32'h8000_0200));

        // Redirect in WAIT, response 3 cycles later, second redirect while dropping.
        lat = 4;
        wait_acc();
        redirect(32'h8000_0300);
        clear_logs();
        tick();
        redirect(32'h8000_0346);
        repeat (3) tick();
        lat = 1;
        wait_push(1);
        b = pb(0);
        chk("p4b_req", 320'(rq(0)), 320'(32'h8000_0340));
        chk("p4b_mask", 320'(vmask(b)), 320'(4'b1110));
        chk("p4b_slot1_pc", 320'(b[1].pc), 320'(32'h8000_0344));

        // Redirect concurrent with a push.
        wait_held();
        redirect(32'h8000_0400);
        clear_logs();
        wait_push(1);
        b = pb(0);
        chk("p5_req", 320'(rq(0)), 320'(32'h8000_0400));
        chk("p5_pc", 320'(b[0].pc), 320'(32'h8000_0400));

        // PC wrap.
        tick();
        redirect(32'hFFFF_FFF0);
        clear_logs();
        for (int k = 0; k < 60 && req_log.size() < 2; k++) tick();
        b = pb(0);
        chk("p6_req0", 320'(rq(0)), 320'(32'hFFFF_FFF0));
        chk("p6_req1", 320'(rq(1)), 320'(32'h0000_0000));
        chk("p6_slot3_pc", 320'(b[3].pc), 320'(32'hFFFF_FFFC));

        // Reset mid-WAIT; the stale response lands after release and is ignored.
        lat = 5;
        wait_acc();
        tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        clear_logs();
        wait_push(1);
        b = pb(0);
        chk("p7_req", 320'(rq(0)), 320'(32'h8000_0000));
        chk("p7_pc", 320'(b[0].pc), 320'(32'h8000_0000));
        chk("p7_mask", 320'(vmask(b)), 320'(4'hF));
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Front-end fetch unit that drives the write side of the fetch buffer. Generates bundle-aligned PCs, issues one I-cache request at a time, captures the returned bundle and pushes it as `INST_FETCH_NUM` `ib_entry_t` slots into the fetch buffer, honouring its full backpressure. Backend redirects (mispredict/exception) flush in-flight work and restart fetch at the new PC.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- `INST_FETCH_NUM` (global macro, 4): instructions per bundle, power of two. BUNDLE_BYTES = 4*`INST_FETCH_NUM`; OFS = log2(BUNDLE_BYTES).

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- icache_req_valid  out  1  request address valid.
- icache_req_addr  out  32  bundle-aligned fetch address (bits [OFS-1:0] = 0).
- icache_req_ready  in  1  I-cache accepts request this cycle.
- icache_resp_valid  in  1  one-cycle pulse; response data valid.
- icache_resp_data  in  32*`INST_FETCH_NUM`  bundle; slot i at bits [32i+31:32i].
- redirect_valid  in  1  restart fetch at redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] ignored (treated as 0).
- fb_full  in  1  fetch buffer cannot accept a bundle this cycle.
- insts_out  out  ib_entry_t[`INST_FETCH_NUM`]  bundle to fetch buffer.
- insts_out_valid  out  1  push strobe into fetch buffer.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Registers: pc (32), bundle register, state.
- IDLE: entered only by reset; next cycle -> REQ.
- REQ: icache_req_valid = !redirect_valid; addr = {pc[31:OFS], OFS'b0}. On valid&&ready -> WAIT.
- WAIT: on icache_resp_valid, capture data into bundle register -> HOLD.
- HOLD: insts_out_valid = !fb_full && !redirect_valid. On push: pc <= {pc[31:OFS],OFS'b0} + BUNDLE_BYTES, -> REQ.
- Slot build: slot i gets inst = data[i], pc = {pc[31:OFS],OFS'b0} + 4i, valid = (i >= pc[OFS-1:2]); slots before an unaligned start PC are invalid.
- Redirect (any state except IDLE) has priority over every same-cycle event: pc <= redirect_pc, no push, no request.
  - REQ/HOLD -> REQ; held bundle discarded.
  - WAIT -> WAIT with drop flag set; the pending response (even if it arrives the same cycle) is discarded, then -> REQ. Further redirects while dropping only update pc.
- Exactly one outstanding I-cache request; responses are in order.
- pc wraps modulo 2^32 (0xFFFF_FFF0 + 16 -> 0x0000_0000 for N=4).

## Timing
- Reset (reset=0): state IDLE, pc = RESET_PC, drop = 0, bundle = 0; icache_req_valid = 0, icache_req_addr = 0, insts_out_valid = 0, insts_out = 0.
- All outputs are functions of registered state plus redirect_valid/fb_full (gating only); no input-to-output path from I-cache data.
- Throughput: one bundle per 2 + L cycles (L = I-cache request-accept to resp latency, >= 1), absent stalls.
- Response in cycle t -> insts_out_valid earliest t+1.
- fb_full held: HOLD indefinitely, bundle stable, no new request.
- Reset asserted mid-WAIT: state cleared; a later stale icache_resp_valid in REQ/IDLE is ignored.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_bundle_cnt, perf_stall_cnt, perf_redirect_cnt (32 b each, reset 0, wrap): pushes, HOLD cycles with fb_full=1, accepted redirects.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- ib_entry_t {valid, pc[31:0], inst[31:0]} and `INST_FETCH_NUM` stay in micro_op.svh; add fetch_state_t enum there.
- Optional sub-module fetch_bundle_align: combinational slot builder (data + pc -> ib_entry_t array).

## Test plan
- Reset release, I-cache ready, L=1, fb_full=0 -> requests 0x8000_0000, 0x8000_0010, 0x8000_0020; pushes every 3 cycles, slot pcs +4.
- Redirect to 0x8000_0108 -> request addr 0x8000_0100; pushed slots 0,1 valid=0, slots 2,3 valid=1 with pcs 0x108, 0x10C.
- fb_full=1 for 10 cycles in HOLD -> no push, no request, bundle stable; push in first cycle fb_full drops.
- Redirect in WAIT with response same cycle and with response 3 cycles later -> both responses discarded; next request at redirect PC.
- Redirect concurrent with push in HOLD -> no push; next request at redirect PC.
- pc = 0xFFFF_FFF0 -> following request 0x0000_0000.
